// File: rtl/mips_cpu_cache_instr_nway.sv
// N-way set-associative instruction cache, one word per line, tree-PLRU replacement.
// Hits return in the same cycle; misses issue a single-word fill and stall until it returns.
`timescale 1ns/1ps

module mips_cpu_cache_instr_nway #(
    parameter int INDEX_BITS = 3,
    parameter int WAYS       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        read_en,
    output logic [31:0] readdata,
    output logic        stall,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    input  logic        mem_valid,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int WAY_BITS = $clog2(WAYS);
    localparam int SETS     = 1 << INDEX_BITS;
    localparam int TAG_BITS = 30 - INDEX_BITS;

    localparam logic [0:0] STATE_IDLE = 1'b0;
    localparam logic [0:0] STATE_MISS = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [31:2]         line_addr_q;
    logic                mem_req_q;
    logic                flush_pend_q;
    logic [31:0]         readdata_q, readdata_d;
    logic [31:0]         hit_count_q, miss_count_q;

    logic [WAYS-1:0]     valid_q [SETS];
    logic [WAYS-2:0]     plru_q  [SETS];
    logic [TAG_BITS-1:0] tag_q   [SETS][WAYS];
    logic [31:0]         data_q  [SETS][WAYS];

    logic [INDEX_BITS-1:0] req_idx, fill_idx;
    logic [TAG_BITS-1:0]   req_tag, fill_tag;
    logic                  hit;
    logic [WAY_BITS-1:0]   hit_way, victim_way;
    logic [31:0]           hit_data;
    logic                  victim_found;

    logic in_idle, in_miss;
    logic count_hit, start_miss, fill_done, flush_now, fill_write, clear_all;

    // Walk from the root following each bit; a 0 bit selects the lower subtree.
    function automatic logic [WAY_BITS-1:0] plru_victim(input logic [WAYS-2:0] bits);
        logic [WAY_BITS-1:0] w;
        int                  node;
        w    = '0;
        node = 0;
        for (int l = 0; l < WAY_BITS; l++) begin
            w[WAY_BITS-1-l] = bits[node];
            node = 2 * node + 1 + int'(bits[node]);
        end
        return w;
    endfunction

    // Every node on the path to way w is set to point at the other subtree.
    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                   input logic [WAY_BITS-1:0] w);
        logic [WAYS-2:0] nb;
        int              node;
        logic            b;
        nb   = bits;
        node = 0;
        for (int l = 0; l < WAY_BITS; l++) begin
            b        = w[WAY_BITS-1-l];
            nb[node] = ~b;
            node     = 2 * node + 1 + int'(b);
        end
        return nb;
    endfunction

    assign req_idx  = addr[INDEX_BITS+1:2];
    assign req_tag  = addr[31:INDEX_BITS+2];
    assign fill_idx = line_addr_q[INDEX_BITS+1:2];
    assign fill_tag = line_addr_q[31:INDEX_BITS+2];

    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        hit_data = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit      = 1'b1;
                hit_way  = WAY_BITS'(w);
                hit_data = data_q[req_idx][w];
            end
        end
    end

    // Fill into the lowest invalid way first; PLRU only decides once the set is full.
    always_comb begin
        victim_way   = plru_victim(plru_q[fill_idx]);
        victim_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!victim_found && !valid_q[fill_idx][w]) begin
                victim_way   = WAY_BITS'(w);
                victim_found = 1'b1;
            end
        end
    end

    assign in_idle    = (state_q == STATE_IDLE);
    assign in_miss    = (state_q == STATE_MISS);
    assign count_hit  = in_idle & read_en & hit;
    assign start_miss = in_idle & read_en & ~hit;
    assign fill_done  = in_miss & mem_valid;
    assign flush_now  = flush_pend_q | flush;
    assign fill_write = fill_done & ~flush_now;
    assign clear_all  = (in_idle & flush) | (fill_done & flush_now);

    always_comb begin
        state_d    = state_q;
        readdata_d = readdata_q;
        if (in_idle) begin
            if (start_miss)
                state_d = STATE_MISS;
            if (count_hit)
                readdata_d = hit_data;
        end else begin
            if (mem_valid) begin
                state_d    = STATE_IDLE;
                readdata_d = mem_data;
            end
        end
    end

    assign readdata   = readdata_d;
    assign stall      = ~rst & (in_idle ? start_miss : ~mem_valid);
    assign mem_req    = mem_req_q;
    assign mem_addr   = {line_addr_q, 2'b00};
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= STATE_IDLE;
            line_addr_q  <= '0;
            mem_req_q    <= 1'b0;
            flush_pend_q <= 1'b0;
            readdata_q   <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            readdata_q <= readdata_d;

            if (start_miss) begin
                line_addr_q <= addr[31:2];
                mem_req_q   <= 1'b1;
                if (miss_count_q != 32'hFFFF_FFFF)
                    miss_count_q <= miss_count_q + 32'd1;
            end else if (fill_done) begin
                mem_req_q <= 1'b0;
            end

            if (count_hit && (hit_count_q != 32'hFFFF_FFFF))
                hit_count_q <= hit_count_q + 32'd1;

            if (in_idle || fill_done)
                flush_pend_q <= 1'b0;
            else if (flush)
                flush_pend_q <= 1'b1;

            // A same-cycle hit still reads old contents, but the clear wins over its PLRU update.
            if (clear_all) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_q[s] <= '0;
                    plru_q[s]  <= '0;
                end
            end else if (count_hit) begin
                plru_q[req_idx] <= plru_touch(plru_q[req_idx], hit_way);
            end else if (fill_write) begin
                valid_q[fill_idx][victim_way] <= 1'b1;
                plru_q[fill_idx]              <= plru_touch(plru_q[fill_idx], victim_way);
            end
        end
    end

    // Tag and data arrays need no reset; valid bits gate every use of them.
    always_ff @(posedge clk) begin
        if (fill_write) begin
            tag_q[fill_idx][victim_way]  <= fill_tag;
            data_q[fill_idx][victim_way] <= mem_data;
        end
    end

endmodule

// File: tb/tb_mips_cpu_cache_instr_nway.sv
// Scoreboard bench: two cache configurations, expected fetch words queued at issue and
// popped by per-instance monitors whenever a fetch completes (read_en & !stall).
`timescale 1ns/1ps

module tb_mips_cpu_cache_instr_nway;

    logic        clk;
    logic        rst;
    logic [31:0] addr_s      [2];
    logic        read_en_s   [2];
    logic [31:0] readdata_s  [2];
    logic        stall_s     [2];
    logic        flush_s     [2];
    logic        mem_req_s   [2];
    logic [31:0] mem_addr_s  [2];
    logic [31:0] mem_data_s  [2];
    logic        mem_valid_s [2];
    logic [31:0] hit_cnt_s   [2];
    logic [31:0] miss_cnt_s  [2];

    int          n_tests;
    int          n_fail;
    logic [31:0] exp_q0 [$];
    logic [31:0] exp_q1 [$];
    int          exp_hits   [2];
    int          exp_misses [2];
    logic [31:0] last_data  [2];

    mips_cpu_cache_instr_nway #(.INDEX_BITS(3), .WAYS(4)) dut0 (
        .clk(clk), .rst(rst), .addr(addr_s[0]), .read_en(read_en_s[0]),
        .readdata(readdata_s[0]), .stall(stall_s[0]), .flush(flush_s[0]),
        .mem_req(mem_req_s[0]), .mem_addr(mem_addr_s[0]), .mem_data(mem_data_s[0]),
        .mem_valid(mem_valid_s[0]), .hit_count(hit_cnt_s[0]), .miss_count(miss_cnt_s[0])
    );

    mips_cpu_cache_instr_nway #(.INDEX_BITS(4), .WAYS(2)) dut1 (
        .clk(clk), .rst(rst), .addr(addr_s[1]), .read_en(read_en_s[1]),
        .readdata(readdata_s[1]), .stall(stall_s[1]), .flush(flush_s[1]),
        .mem_req(mem_req_s[1]), .mem_addr(mem_addr_s[1]), .mem_data(mem_data_s[1]),
        .mem_valid(mem_valid_s[1]), .hit_count(hit_cnt_s[1]), .miss_count(miss_cnt_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Backing-store contents: a fixed pattern, with the cold-miss word pinned to DEADBEEF.
    function automatic logic [31:0] mdata(input logic [31:0] a);
        if (a == 32'h0000_0040)
            return 32'hDEAD_BEEF;
        return a ^ 32'hC0DE_5A00;
    endfunction

    always @(negedge clk) begin
        if (!rst && read_en_s[0] && !stall_s[0]) begin
            if (exp_q0.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb0_unexpected: got %h expected none", readdata_s[0]);
            end else begin
                chk("sb0_readdata", readdata_s[0], exp_q0.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && read_en_s[1] && !stall_s[1]) begin
            if (exp_q1.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb1_unexpected: got %h expected none", readdata_s[1]);
            end else begin
                chk("sb1_readdata", readdata_s[1], exp_q1.pop_front());
            end
        end
    end

    // One fetch; for a miss, mem_valid arrives lat cycles after the first mem_req cycle.
    task automatic fetch(input int d, input logic [31:0] a, input bit exp_hit, input int lat,
                         input bit fl_issue, input bit fl_miss);
        logic [31:0] expd;
        int          stalls;
        expd   = mdata(a);
        stalls = 0;
        @(posedge clk); #1;
        addr_s[d]    = a;
        read_en_s[d] = 1'b1;
        flush_s[d]   = fl_issue;
        if (d == 0) exp_q0.push_back(expd);
        else        exp_q1.push_back(expd);
        @(negedge clk);
        chk("issue_stall", 32'(stall_s[d]), 32'(!exp_hit));
        if (stall_s[d]) stalls++;
        if (!exp_hit) begin
            exp_misses[d]++;
            @(posedge clk); #1;
            flush_s[d] = fl_miss;
            @(negedge clk);
            chk("miss_req", 32'(mem_req_s[d]), 32'd1);
            chk("miss_addr", mem_addr_s[d], {a[31:2], 2'b00});
            if (stall_s[d]) stalls++;
            for (int k = 1; k < lat; k++) begin
                @(posedge clk); #1;
                flush_s[d] = 1'b0;
                @(negedge clk);
                if (stall_s[d]) stalls++;
            end
            @(posedge clk); #1;
            flush_s[d]     = 1'b0;
            mem_valid_s[d] = 1'b1;
            mem_data_s[d]  = expd;
            @(negedge clk);
            chk("fill_req", 32'(mem_req_s[d]), 32'd1);
            if (stall_s[d]) stalls++;
            chk("stall_cycles", 32'(stalls), 32'(1 + lat));
            @(posedge clk); #1;
            mem_valid_s[d] = 1'b0;
            read_en_s[d]   = 1'b0;
            @(negedge clk);
            chk("req_drop", 32'(mem_req_s[d]), 32'd0);
        end else begin
            exp_hits[d]++;
            @(posedge clk); #1;
            read_en_s[d] = 1'b0;
            flush_s[d]   = 1'b0;
        end
        last_data[d] = expd;
    endtask

    task automatic check_state(input int d);
        @(negedge clk);
        chk("hit_count", hit_cnt_s[d], 32'(exp_hits[d]));
        chk("miss_count", miss_cnt_s[d], 32'(exp_misses[d]));
        chk("readdata_hold", readdata_s[d], last_data[d]);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        for (int d = 0; d < 2; d++) begin
            addr_s[d]      = '0;
            read_en_s[d]   = 1'b0;
            flush_s[d]     = 1'b0;
            mem_data_s[d]  = '0;
            mem_valid_s[d] = 1'b0;
            exp_hits[d]    = 0;
            exp_misses[d]  = 0;
            last_data[d]   = '0;
        end
        #2;
        for (int d = 0; d < 2; d++) begin
            chk("rst_stall", 32'(stall_s[d]), 32'd0);
            chk("rst_req", 32'(mem_req_s[d]), 32'd0);
            chk("rst_addr", mem_addr_s[d], 32'd0);
            chk("rst_readdata", readdata_s[d], 32'd0);
            chk("rst_hits", hit_cnt_s[d], 32'd0);
            chk("rst_misses", miss_cnt_s[d], 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // Cold miss and same-cycle re-read hit.
        fetch(0, 32'h40, 1'b0, 2, 1'b0, 1'b0);
        fetch(0, 32'h40, 1'b1, 1, 1'b0, 1'b0);
        check_state(0);

        // Fill set 0 (0x40 already in way 0), touch 0x00 and 0x40, then 0x80 evicts 0x20.
        fetch(0, 32'h00, 1'b0, 1, 1'b0, 1'b0);
        fetch(0, 32'h20, 1'b0, 3, 1'b0, 1'b0);
        fetch(0, 32'h40, 1'b1, 1, 1'b0, 1'b0);
        fetch(0, 32'h60, 1'b0, 1, 1'b0, 1'b0);
        fetch(0, 32'h00, 1'b1, 1, 1'b0, 1'b0);
        fetch(0, 32'h40, 1'b1, 1, 1'b0, 1'b0);
        fetch(0, 32'h80, 1'b0, 2, 1'b0, 1'b0);
        fetch(0, 32'h00, 1'b1, 1, 1'b0, 1'b0);
        fetch(0, 32'h40, 1'b1, 1, 1'b0, 1'b0);
        fetch(0, 32'h60, 1'b1, 1, 1'b0, 1'b0);
        fetch(0, 32'h20, 1'b0, 1, 1'b0, 1'b0);
        check_state(0);

        // Flush in IDLE alongside a hit (0x00 was just evicted by 0x20, so use 0x40).
        fetch(0, 32'h40, 1'b1, 1, 1'b1, 1'b0);
        fetch(0, 32'h40, 1'b0, 1, 1'b0, 1'b0);
        check_state(0);

        // Flush one cycle into a miss: word forwarded, nothing retained.
        fetch(0, 32'h100, 1'b0, 2, 1'b0, 1'b1);
        fetch(0, 32'h100, 1'b0, 1, 1'b0, 1'b0);
        fetch(0, 32'h100, 1'b1, 1, 1'b0, 1'b0);
        check_state(0);

        // Async reset in the middle of an outstanding fill.
        fetch(0, 32'h00, 1'b0, 1, 1'b0, 1'b0);
        @(posedge clk); #1;
        addr_s[0]    = 32'h20;
        read_en_s[0] = 1'b1;
        @(posedge clk); #1;
        chk("pre_rst_req", 32'(mem_req_s[0]), 32'd1);
        #1;
        rst = 1'b1;
        exp_q0.delete();
        #1;
        chk("arst_req", 32'(mem_req_s[0]), 32'd0);
        chk("arst_stall", 32'(stall_s[0]), 32'd0);
        chk("arst_readdata", readdata_s[0], 32'd0);
        chk("arst_hits", hit_cnt_s[0], 32'd0);
        chk("arst_misses", miss_cnt_s[0], 32'd0);
        read_en_s[0] = 1'b0;
        exp_hits[0]   = 0;
        exp_misses[0] = 0;
        last_data[0]  = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        mem_valid_s[0] = 1'b1;
        mem_data_s[0]  = 32'h1234_5678;
        @(negedge clk);
        chk("late_valid_req", 32'(mem_req_s[0]), 32'd0);
        chk("late_valid_data", readdata_s[0], 32'd0);
        @(posedge clk); #1;
        mem_valid_s[0] = 1'b0;
        fetch(0, 32'h00, 1'b0, 1, 1'b0, 1'b0);
        check_state(0);

        // Two-way, sixteen-set instance.
        fetch(1, 32'h000, 1'b0, 1, 1'b0, 1'b0);
        fetch(1, 32'h040, 1'b0, 2, 1'b0, 1'b0);
        fetch(1, 32'h040, 1'b1, 1, 1'b0, 1'b0);
        fetch(1, 32'h080, 1'b0, 1, 1'b0, 1'b0);
        fetch(1, 32'h040, 1'b1, 1, 1'b0, 1'b0);
        fetch(1, 32'h000, 1'b0, 1, 1'b0, 1'b0);
        check_state(1);

        chk("sb0_left", 32'(exp_q0.size()), 32'd0);
        chk("sb1_left", 32'(exp_q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
